mem_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the cache-to-memory bus, so two cache instances (dual-core configuration) share one `mem`. Each requester issues whole-line read or write bursts. The arbiter grants one requester at a time with round-robin fairness. It drives the memory-side handshake, counts the line beats, and routes beat strobes and data to and from the granted requester. Per-requester saturating grant counters feed the statistics dump.

---
 rtl/mem_bus_arbiter_if.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side handshake bundle for mem_bus_arbiter.
// master is the arbiter's view; slave is the view of the requesters plus the memory.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  // Requester side
  logic [1:0]        rq_req;
  logic [1:0]        rq_we;
  logic [ADDR_W-1:0] rq_addr0;
  logic [ADDR_W-1:0] rq_addr1;
  logic [DATA_W-1:0] rq_wdata0;
  logic [DATA_W-1:0] rq_wdata1;
  logic [1:0]        rq_gnt;
  logic [1:0]        rq_beat;
  logic [DATA_W-1:0] rq_rdata;
  logic [1:0]        rq_done;

  // Memory side
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ack;
  logic              m_beat;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    input  rq_req, rq_we, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1,
    output rq_gnt, rq_beat, rq_rdata, rq_done,
    output m_req, m_we, m_addr, m_wdata,
    input  m_ack, m_beat, m_rdata
  );

  modport slave (
    output rq_req, rq_we, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1,
    input  rq_gnt, rq_beat, rq_rdata, rq_done,
    input  m_req, m_we, m_addr, m_wdata,
    output m_ack, m_beat, m_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer letting two cache requesters share one line-burst memory.
// Grants one whole line transaction at a time and keeps saturating per-requester grant counts.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int LINE_BEATS = 8,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              RESET,
  mem_bus_arbiter_if.master bus,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
);

  localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              g_q, g_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_q, last_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [STAT_W-1:0] cnt0_q, cnt0_d;
  logic [STAT_W-1:0] cnt1_q, cnt1_d;

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b1;
      beat_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // Next-state logic
  // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    we_d    = we_q;
    addr_d  = addr_q;
    last_d  = last_q;
    beat_d  = beat_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    unique case (state_q)
      IDLE: begin
        if (bus.rq_req != 2'b00) begin
          // On a tie the requester that did not win last time gets the bus.
          g_d     = (bus.rq_req == 2'b11) ? ~last_q : bus.rq_req[1];
          we_d    = bus.rq_we[g_d];
          addr_d  = g_d ? bus.rq_addr1 : bus.rq_addr0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ack) begin
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (bus.m_beat) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        last_d  = g_q;
        state_d = IDLE;
        if (!g_q && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
        if (g_q && (cnt1_q != '1))  cnt1_d = cnt1_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: beats and data are steered combinationally to/from the granted requester.
  always_comb begin
    bus.rq_gnt   = 2'b00;
    bus.rq_beat  = 2'b00;
    bus.rq_done  = 2'b00;
    bus.rq_rdata = '0;
    bus.m_req    = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;

    if (state_q != IDLE) begin
      bus.rq_gnt[g_q] = 1'b1;
      bus.m_we        = we_q;
      bus.m_addr      = addr_q;
    end

    unique case (state_q)
      ISSUE: bus.m_req = 1'b1;
      XFER: begin
        bus.rq_beat[g_q] = bus.m_beat;
        if (we_q) bus.m_wdata  = g_q ? bus.rq_wdata1 : bus.rq_wdata0;
        else      bus.rq_rdata = bus.m_rdata;
      end
      DONE:    bus.rq_done[g_q] = 1'b1;
      default: ;
    endcase
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays both requesters and the memory,
// queuing expected grants and beat data as it drives them and comparing as the DUT responds.
module tb_mem_bus_arbiter;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 16;
  localparam int LINE_BEATS = 8;
  localparam int STAT_W     = 4;
  localparam int STAT_MAX   = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [STAT_W-1:0] gc0, gc1;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BEATS(LINE_BEATS), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .RESET(rst), .bus(bus), .grant_cnt0(gc0), .grant_cnt1(gc1)
  );

  // Per-requester stimulus state
  logic [ADDR_W-1:0] addr_v [2];
  logic [DATA_W-1:0] wdata_v[2];
  logic [DATA_W-1:0] base_v [2];
  logic              we_v   [2];

  assign bus.rq_addr0  = addr_v[0];
  assign bus.rq_addr1  = addr_v[1];
  assign bus.rq_wdata0 = wdata_v[0];
  assign bus.rq_wdata1 = wdata_v[1];
  assign bus.rq_we     = {we_v[1], we_v[0]};

  // Scoreboard and reference counters
  int                n_pass  = 0;
  int                n_total = 0;
  int                gnt_q[$];
  logic [DATA_W-1:0] data_q[$];
  int                exp_cnt[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},   bus.rq_gnt,   0);
    check({tag, "_beat"},  bus.rq_beat,  0);
    check({tag, "_done"},  bus.rq_done,  0);
    check({tag, "_rdata"}, bus.rq_rdata, 0);
    check({tag, "_mreq"},  bus.m_req,    0);
    check({tag, "_mwe"},   bus.m_we,     0);
    check({tag, "_maddr"}, bus.m_addr,   0);
    check({tag, "_cnt0"},  gc0,          0);
    check({tag, "_cnt1"},  gc1,          0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.rq_req   = 2'b00;
    bus.m_ack    = 1'b0;
    bus.m_beat   = 1'b0;
    bus.m_rdata  = '0;
    repeat (2) @(negedge clk);
    rst          = 1'b0;
    exp_cnt[0]   = 0;
    exp_cnt[1]   = 0;
    data_q.delete();
    gnt_q.delete();
  endtask

  // Service one granted transaction as requester + memory; returns in the IDLE cycle after DONE.
  task automatic serve(input int ack_delay, input int gap, input bit drop_req, input bit reraise);
    int                waited;
    int                g;
    logic [ADDR_W-1:0] a;
    logic              we;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] d;
    waited = 0;
    while (bus.rq_gnt == 2'b00 && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    g    = gnt_q.pop_front();
    a    = addr_v[g];
    we   = we_v[g];
    base = base_v[g];
    check("grant", bus.rq_gnt, 32'd1 << g);
    check("m_req", bus.m_req, 1);
    check("m_addr", bus.m_addr, a);
    check("m_we", bus.m_we, we);

    // The arbiter must ignore any change on the requester side after grant.
    if (drop_req) bus.rq_req[g] = 1'b0;
    addr_v[g] = ~a;
    we_v[g]   = ~we;

    repeat (ack_delay) begin
      @(negedge clk); #1;
      check("m_req_hold", bus.m_req, 1);
      check("m_addr_hold", bus.m_addr, a);
    end
    bus.m_ack = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;

    for (int k = 0; k < LINE_BEATS; k++) begin
      repeat (gap) begin
        bus.m_beat = 1'b0;
        #1;
        check("no_beat_in_gap", bus.rq_beat, 0);
        @(negedge clk);
      end
      d = base + DATA_W'(k);
      if (we) wdata_v[g]  = d;
      else    bus.m_rdata = d;
      data_q.push_back(d);
      bus.m_beat = 1'b1;
      #1;
      check("rq_beat", bus.rq_beat, 32'd1 << g);
      check("m_addr_xfer", bus.m_addr, a);
      if (we) check("m_wdata", bus.m_wdata, data_q.pop_front());
      else    check("rq_rdata", bus.rq_rdata, data_q.pop_front());
      @(negedge clk);
      bus.m_beat = 1'b0;
    end

    #1;
    check("rq_done", bus.rq_done, 32'd1 << g);
    check("gnt_in_done", bus.rq_gnt, 32'd1 << g);
    if (!reraise) bus.rq_req[g] = 1'b0;
    if (exp_cnt[g] < STAT_MAX) exp_cnt[g]++;

    @(negedge clk); #1;
    check("done_one_cycle", bus.rq_done, 0);
    check("idle_gnt", bus.rq_gnt, 0);
    check("grant_cnt0", gc0, exp_cnt[0]);
    check("grant_cnt1", gc1, exp_cnt[1]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
      base_v[i]  = '0;
      we_v[i]    = 1'b0;
    end

    // Reset state
    do_reset();
    #1;
    check_idle_outputs("reset");

    // Single read from requester 0, memory acks two cycles after m_req
    @(negedge clk);
    addr_v[0] = 14'h0123; we_v[0] = 1'b0; base_v[0] = 16'hA000;
    bus.rq_req = 2'b01;
    gnt_q.push_back(0);
    @(negedge clk); #1;
    check("grant_latency", bus.rq_gnt, 2'b01);
    serve(2, 0, 1'b0, 1'b0);

    // Single write from requester 1 to the top line, beats on every other cycle
    addr_v[1] = 14'h3FFF; we_v[1] = 1'b1; base_v[1] = 16'hB000;
    bus.rq_req = 2'b10;
    gnt_q.push_back(1);
    serve(0, 1, 1'b0, 1'b0);

    // Both requesters held high for three rounds each: strict alternation from a fresh reset
    do_reset();
    @(negedge clk);
    addr_v[0] = 14'h0040; we_v[0] = 1'b0; base_v[0] = 16'hC000;
    addr_v[1] = 14'h1080; we_v[1] = 1'b1; base_v[1] = 16'hD000;
    bus.rq_req = 2'b11;
    for (int r = 0; r < 3; r++) begin
      gnt_q.push_back(0);
      gnt_q.push_back(1);
    end
    for (int t = 0; t < 6; t++) serve(1, 0, 1'b0, (t < 4));
    check("rr_cnt0", gc0, 3);
    check("rr_cnt1", gc1, 3);

    // Request withdrawn during ISSUE still completes the whole line
    addr_v[0] = 14'h0200; we_v[0] = 1'b0; base_v[0] = 16'hE000;
    bus.rq_req = 2'b01;
    gnt_q.push_back(0);
    serve(1, 0, 1'b1, 1'b0);

    // Reset asserted after three beats of a read
    addr_v[0] = 14'h0555; we_v[0] = 1'b0;
    bus.rq_req = 2'b01;
    @(negedge clk); #1;
    check("rst_test_gnt", bus.rq_gnt, 2'b01);
    bus.m_ack = 1'b1;
    @(negedge clk);
    bus.m_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.m_beat  = 1'b1;
      bus.m_rdata = 16'h5A00 + 16'(k);
      @(negedge clk);
    end
    bus.m_beat  = 1'b0;
    bus.m_rdata = 16'hA5A5;
    bus.rq_req  = 2'b00;
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;

    // Stray m_beat / m_ack in IDLE must do nothing
    bus.m_beat = 1'b1;
    bus.m_ack  = 1'b1;
    #1;
    check("stray_beat", bus.rq_beat, 0);
    check("stray_gnt", bus.rq_gnt, 0);
    @(negedge clk);
    bus.m_beat = 1'b0;
    bus.m_ack  = 1'b0;
    #1;
    check("stray_state", bus.rq_gnt, 0);
    check("stray_mreq", bus.m_req, 0);

    // Full transaction after reset release
    addr_v[0] = 14'h0777; we_v[0] = 1'b0; base_v[0] = 16'h1000;
    bus.rq_req = 2'b01;
    gnt_q.push_back(0);
    serve(0, 0, 1'b0, 1'b0);

    // Grant counter saturation: 16 more transactions makes 17 in total
    for (int t = 0; t < 16; t++) begin
      base_v[0]  = 16'h2000 + 16'(t << 4);
      bus.rq_req = 2'b01;
      gnt_q.push_back(0);
      serve(0, 0, 1'b0, 1'b0);
    end
    check("sat_cnt0", gc0, STAT_MAX);
    check("sat_cnt1", gc1, 0);

    check("scoreboard_empty", data_q.size() + gnt_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
